// File: rtl/fir_tap_buffer.sv
// -----------------------------------------------------------------------------
// fir_tap_buffer
//
// Coefficient store for the FIR HWPE. Receives packed 32-bit beats from the H
// source streamer, splits each beat into two 16-bit taps and holds the full
// tap set in registers for the datapath. A one-cycle done pulse tells the
// controller the set is complete.
//
// Parameters
//   NB_TAPS    number of taps stored (>= 1, odd allowed)
//   TAP_WIDTH  tap width, fixed at 16 (two taps per 32-bit beat)
//
// Ports
//   clk_i      clock
//   rst_ni     asynchronous active-low reset
//   clear_i    synchronous clear: back to IDLE, taps zeroed
//   start_i    one-cycle pulse, begins (or restarts) a load
//   h_valid_i  H stream valid
//   h_ready_o  H stream ready (decoded from registered state only)
//   h_data_i   H stream data, tap 2k in [15:0], tap 2k+1 in [31:16]
//   taps_o     stored taps, taps_o[i] is tap i
//   done_o     one-cycle pulse, first cycle after the final handshake
//   full_o     level, buffer holds a complete tap set
//
// Build option
//   FIR_TAP_BUFFER_REVERSE_EN  when defined, memory word i lands in
//                              taps_o[NB_TAPS-1-i] (time-reversed taps)
// -----------------------------------------------------------------------------
module fir_tap_buffer #(
    parameter int NB_TAPS   = 50,
    parameter int TAP_WIDTH = 16
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 clear_i,
    input  logic                                 start_i,
    input  logic                                 h_valid_i,
    output logic                                 h_ready_o,
    input  logic [2*TAP_WIDTH-1:0]               h_data_i,
    output logic [NB_TAPS-1:0][TAP_WIDTH-1:0]    taps_o,
    output logic                                 done_o,
    output logic                                 full_o
);

    localparam int NB_BEATS = (NB_TAPS + 1) / 2;
    localparam int CNT_W    = $clog2(NB_BEATS + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_FULL = 2'b10
    } state_t;

    state_t                             state_r;
    state_t                             state_s;
    logic [CNT_W-1:0]                   cnt_r;
    logic [CNT_W-1:0]                   cnt_s;
    logic                               done_r;
    logic                               done_s;
    logic                               wr_en_s;
    logic                               handshake_s;
    logic [NB_TAPS-1:0][TAP_WIDTH-1:0]  taps_r;

    // Output index of memory word i; reversal is a pure wiring choice.
    function automatic int tap_idx(input int i);
`ifdef FIR_TAP_BUFFER_REVERSE_EN
        return NB_TAPS - 1 - i;
`else
        return i;
`endif
    endfunction

    assign h_ready_o   = (state_r == ST_LOAD);
    assign full_o      = (state_r == ST_FULL);
    assign done_o      = done_r;
    assign taps_o      = taps_r;
    assign handshake_s = h_valid_i & h_ready_o;

    // Next-state, beat counter and write-enable decode.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        done_s  = 1'b0;
        wr_en_s = 1'b0;
        if (clear_i) begin
            state_s = ST_IDLE;
            cnt_s   = {CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_i) begin
                        state_s = ST_LOAD;
                        cnt_s   = {CNT_W{1'b0}};
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    // A restart wins over a coincident beat: the beat is dropped.
                    if (start_i) begin
                        cnt_s = {CNT_W{1'b0}};
                    end else if (handshake_s) begin
                        wr_en_s = 1'b1;
                        cnt_s   = cnt_r + CNT_W'(1);
                        if (cnt_r == CNT_W'(NB_BEATS - 1)) begin
                            state_s = ST_FULL;
                            done_s  = 1'b1;
                        end else begin
                            state_s = ST_LOAD;
                        end
                    end else begin
                        state_s = ST_LOAD;
                    end
                end
                ST_FULL: begin
                    if (start_i) begin
                        state_s = ST_LOAD;
                        cnt_s   = {CNT_W{1'b0}};
                    end else begin
                        state_s = ST_FULL;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                    cnt_s   = {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // State, counter and done pulse registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            done_r  <= done_s;
        end
    end

    // Tap storage: beat k writes memory words 2k and 2k+1; a word index at or
    // beyond NB_TAPS simply has no register, which discards the odd upper half.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            taps_r <= '0;
        end else if (clear_i) begin
            taps_r <= '0;
        end else begin
            for (int i = 0; i < NB_TAPS; i++) begin
                if (wr_en_s && (cnt_r == CNT_W'(i / 2))) begin
                    if ((i % 2) == 0) begin
                        taps_r[tap_idx(i)] <= h_data_i[TAP_WIDTH-1:0];
                    end else begin
                        taps_r[tap_idx(i)] <= h_data_i[2*TAP_WIDTH-1:TAP_WIDTH];
                    end
                end
            end
        end
    end

endmodule
